// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a small byte FIFO (TXDATA 0x070, STATUS 0x074).
// Optional even-parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter int BAUD_DIV   = 10416,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IOWrite,
    input  logic        IORead,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          push, pop, full, empty, busy, baud_end;
    logic [4:0]    count_w;
    logic [2:0]    count_sat;
    logic          unused_wdata;

    assign full      = count_q == FULL_CNT;
    assign empty     = count_q == '0;
    assign busy      = state_q != IDLE;
    assign push      = IOWrite && addr == 10'h070 && !full;
    assign pop       = state_q == IDLE && !empty;
    assign baud_end  = baud_q == BAUD_LAST;
    assign count_w   = 5'(count_q);
    assign count_sat = count_w > 5'd7 ? 3'd7 : count_w[2:0];
    assign rdata     = (IORead && addr == 10'h074) ? {26'b0, count_sat, busy, empty, full} : 32'b0;
    assign tx        = tx_q;
    assign unused_wdata = ^wdata[31:8];

    // Occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = push && !pop ? count_q + 1'b1 : pop && !push ? count_q - 1'b1 : count_q;
    end

    // FIFO storage is data-only, so it needs no reset
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= wdata[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Frame sequencer with registered serial output; the shift register holds the byte unchanged and bit_q selects the bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        state_q <= START;
                        tx_q    <= 1'b0;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    baud_q <= baud_end ? 16'd0 : baud_q + 16'd1;
                    if (baud_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    baud_q <= baud_end ? 16'd0 : baud_q + 16'd1;
                    if (baud_end && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_q <= PARITY;
                        tx_q    <= ^shift_q;
`else
                        state_q <= STOP;
                        tx_q    <= 1'b1;
`endif
                    end else if (baud_end) begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= shift_q[bit_q + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    baud_q <= baud_end ? 16'd0 : baud_q + 16'd1;
                    if (baud_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    baud_q <= baud_end ? 16'd0 : baud_q + 16'd1;
                    if (baud_end) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench for uart_tx_mmio (BAUD_DIV=4, FIFO_DEPTH=4); honours UART_TX_PARITY_EN.
module tb_uart_tx_mmio;
    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        IOWrite, IORead;
    logic [9:0]  addr;
    logic [31:0] wdata, rdata;
    logic        tx;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  sb [$];
    int          ph = -1;
    int          idle_cnt = 0;
    int          last_gap = 0;
    logic [43:0] smp;
    logic [31:0] s;
    logic        found;

    uart_tx_mmio #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .IOWrite(IOWrite), .IORead(IORead),
        .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d, input bit keep);
        IOWrite = 1'b1;
        addr    = a;
        wdata   = {24'hDEAD_BE, d};
        if (keep) sb.push_back(d);
        @(negedge clock);
        IOWrite = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        IORead = 1'b1;
        addr   = a;
        #1 d   = rdata;
        IORead = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && (sb.size() != 0 || ph >= 0); i++) @(negedge clock);
        check("drain_remaining", sb.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic frame_check();
        int bad;
        logic [7:0] d;
        bad = 0;
        for (int b = 0; b < NB; b++)
            for (int k = 1; k < BD; k++)
                if (smp[b*BD+k] !== smp[b*BD]) bad++;
        check("bit_width", bad, 0);
        for (int i = 0; i < 8; i++) d[i] = smp[(i+1)*BD];
`ifdef UART_TX_PARITY_EN
        check("parity_bit", smp[9*BD], ^d);
`endif
        check("stop_bit", smp[(NB-1)*BD], 1);
        if (sb.size() == 0) check("frame_expected", sb.size(), 1);
        else check("frame_data", d, sb.pop_front());
    endtask

    // Line monitor: captures one sample per cycle from the start bit and decodes full frames
    always @(negedge clock) begin
        if (!reset) begin
            ph = -1;
            idle_cnt = 0;
        end else if (ph < 0) begin
            if (tx === 1'b0) begin
                last_gap = idle_cnt;
                idle_cnt = 0;
                smp = '0;
                ph = 1;
            end else idle_cnt++;
        end else begin
            smp[ph] = tx;
            ph++;
            if (ph == NB*BD) begin
                frame_check();
                ph = -1;
            end
        end
    end

    initial begin
        reset = 1'b0; IOWrite = 1'b0; IORead = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        rd(10'h074, s); check("rst_status", s, 32'h2);
        reset = 1'b1;
        @(negedge clock);

        wr(10'h070, 8'h55, 1);
        check("lat_idle_tx", tx, 1);
        @(negedge clock);
        check("lat_start_tx", tx, 0);
        rd(10'h074, s); check("busy_status", s, 32'h6);
        wait_drain();

        wr(10'h078, 8'hAA, 0);
        wr(10'h074, 8'hFF, 0);
        repeat (10) @(negedge clock);
        rd(10'h074, s); check("decode_status", s, 32'h2);
        check("decode_tx", tx, 1);
        rd(10'h070, s); check("rd_txdata", s, 32'h0);
        rd(10'h078, s); check("rd_other", s, 32'h0);

        @(negedge clock);
        wr(10'h070, 8'hA5, 1);
        repeat (2) @(negedge clock);
        for (int i = 1; i <= 5; i++) wr(10'h070, 8'(i), i <= 4);
        rd(10'h074, s); check("full_status", s, 32'h25);
        wait_drain();
        check("overflow_gap", last_gap, 1);

        @(negedge clock);
        wr(10'h070, 8'h81, 1);
        wr(10'h070, 8'h42, 1);
        repeat (4) @(negedge clock);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            rd(10'h074, s);
            if (!s[2]) found = 1'b1;
        end
        check("idle_found", found, 1);
        check("idle_status", s, 32'h8);
        wr(10'h070, 8'h3C, 1);
        rd(10'h074, s); check("pushpop_status", s, 32'hC);
        wait_drain();
        check("pushpop_gap", last_gap, 1);

        @(negedge clock);
        wr(10'h070, 8'h96, 1);
        wr(10'h070, 8'h11, 1);
        repeat (17) @(negedge clock);
        check("bit3_tx", tx, 0);
        #2 reset = 1'b0;
        sb.delete();
        #1 check("async_rst_tx", tx, 1);
        rd(10'h074, s); check("in_rst_status", s, 32'h2);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("post_rst_tx", tx, 1);
        rd(10'h074, s); check("post_rst_status", s, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BAUD_DIV, default 10416, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of two, 2..16.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 IOWrite  input  1  IO-space store strobe from the CPU control unit.
REQ-006 IORead  input  1  IO-space load strobe from the CPU control unit.
REQ-007 addr  input  10  low 10 bits of the ALU result (IO offset).
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load data.
REQ-010 tx  output  1  serial line, idle high.

Function
REQ-011 The block SHALL respond only at offsets 0x070 (TXDATA) and 0x074 (STATUS); all other offsets SHALL be ignored.
REQ-012 IOWrite at 0x070 SHALL push wdata[7:0] into the FIFO at the clock edge, unless count==FIFO_DEPTH, in which case the write SHALL be dropped, even if a pop occurs in the same cycle.
REQ-013 IOWrite at 0x074 SHALL have no effect.
REQ-014 rdata SHALL be combinational: when IORead is high and addr==0x074, rdata = {26'b0, count[2:0] saturated to 7, busy, empty, full} (bit0 full, bit1 empty, bit2 busy, bits[5:3] count); otherwise rdata = 0.
REQ-015 busy SHALL be high whenever the FSM is not in IDLE.
REQ-016 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE: tx=1; if FIFO not empty, pop the head into an 8-bit shift register and enter START at the same edge.
REQ-018 START: tx=0 for BAUD_DIV cycles, then enter DATA.
REQ-019 DATA: tx=shift[0] for BAUD_DIV cycles per bit, LSB first, 8 bits, then enter PARITY if compiled in, else STOP.
REQ-020 STOP: tx=1 for BAUD_DIV cycles, then return to IDLE; consecutive frames are therefore separated by exactly one idle cycle.
REQ-021 The baud counter SHALL reload at every state or bit transition and count from 0 to BAUD_DIV-1.
REQ-022 Latency: a push at edge N into an empty FIFO in IDLE SHALL drive tx low from edge N+1.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 tx SHALL come from a register (glitch-free).

Reset
REQ-025 While reset is low: FSM=IDLE, tx=1, FIFO empty (pointers and count = 0), baud and bit counters = 0, shift register = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and discard all queued bytes.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state SHALL follow DATA, driving the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles, giving an 11-bit frame; when undefined, there SHALL be no PARITY state and the frame SHALL be 10 bits.

Verification (bench BAUD_DIV=4, FIFO_DEPTH=4)
REQ-028 Single byte: write 0x55 to 0x070 -> tx low from the next edge for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles; with parity enabled, parity bit 0 precedes the stop bit.
REQ-029 Overflow: 5 back-to-back writes 0x01..0x05 while busy -> STATUS reads full=1, count=4; 0x05 is never transmitted; 0x01..0x04 are sent in order.
REQ-030 Status: after reset, IORead at 0x074 -> rdata=0x00000002; during a frame with an empty FIFO -> 0x00000006.
REQ-031 Decode: IOWrite at 0x078 with 0xAA -> no frame, count stays 0; IORead at 0x070 -> rdata=0.
REQ-032 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately; after release STATUS=0x00000002 and tx stays high.
REQ-033 Simultaneous push/pop: FIFO holds 1 byte, FSM in IDLE, write 0x3C in the pop cycle -> count stays 1, and 0x3C follows the current frame after one idle cycle.
